// File: rtl/fibonacci_checker.sv
// Streaming Fibonacci checker: locks onto a two-sample seed, then verifies
// F(n) = F(n-1) + F(n-2) mod 2^32 on every accepted sample.
module fibonacci_checker #(
    parameter bit STRICT_SEED = 1'b0,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      fib,
    output logic             locked,
    output logic             error,
    output logic             wrapped,
    output logic [31:0]      expected,
    output logic [31:0]      match_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SEED1 = 2'b01,
        TRACK = 2'b10
    } state_t;

    state_t            state_r, state_s;
    logic [31:0]       prev0_r, prev1_r;
    logic [31:0]       prev0_s, prev1_s;
    logic [31:0]       expected_r;
    logic [31:0]       match_count_r;
    logic [ERR_W-1:0]  err_count_r;
    logic              locked_r, error_r, wrapped_r;
    logic              err_s, match_s;
    logic [32:0]       sum_s;

    // Next-state, sample-pair update and error/match decode
    always_comb begin
        state_s = state_r;
        prev0_s = prev0_r;
        prev1_s = prev1_r;
        err_s   = 1'b0;
        match_s = 1'b0;
        if (in_valid) begin
            case (state_r)
                EMPTY: begin
                    if (STRICT_SEED && (fib != 32'd0)) begin
                        err_s = 1'b1;
                    end else begin
                        prev1_s = fib;
                        state_s = SEED1;
                    end
                end
                SEED1: begin
                    if (STRICT_SEED && (fib != 32'd1)) begin
                        err_s   = 1'b1;
                        state_s = EMPTY;
                    end else begin
                        prev0_s = prev1_r;
                        prev1_s = fib;
                        state_s = TRACK;
                    end
                end
                TRACK: begin
                    if (fib == expected_r) begin
                        match_s = 1'b1;
                        prev0_s = prev1_r;
                        prev1_s = fib;
                    end else begin
                        err_s = 1'b1;
                        if (STRICT_SEED) begin
                            state_s = EMPTY;
                        end else begin
                            // The offending sample restarts the seed pair
                            prev1_s = fib;
                            state_s = SEED1;
                        end
                    end
                end
                default: begin
                    state_s = EMPTY;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Carry out of bit 31 flags a wrap of the predicted value
    always_comb begin
        sum_s = {1'b0, prev0_s} + {1'b0, prev1_s};
    end

    // State, sample pair, outputs and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= EMPTY;
            prev0_r       <= 32'd0;
            prev1_r       <= 32'd0;
            expected_r    <= 32'd0;
            locked_r      <= 1'b0;
            error_r       <= 1'b0;
            wrapped_r     <= 1'b0;
            match_count_r <= 32'd0;
            err_count_r   <= {ERR_W{1'b0}};
        end else begin
            state_r    <= state_s;
            prev0_r    <= prev0_s;
            prev1_r    <= prev1_s;
            expected_r <= sum_s[31:0];
            locked_r   <= (state_s == TRACK);
            error_r    <= err_s;
            // Only a prediction actually used for tracking can mark a wrap
            if (in_valid && (state_s == TRACK) && sum_s[32]) begin
                wrapped_r <= 1'b1;
            end else begin
                wrapped_r <= wrapped_r;
            end
            if (match_s && (match_count_r != 32'hFFFF_FFFF)) begin
                match_count_r <= match_count_r + 32'd1;
            end else begin
                match_count_r <= match_count_r;
            end
            if (err_s && (err_count_r != {ERR_W{1'b1}})) begin
                err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign locked      = locked_r;
    assign error       = error_r;
    assign wrapped     = wrapped_r;
    assign expected    = expected_r;
    assign match_count = match_count_r;
    assign err_count   = err_count_r;

endmodule
